// File: rtl/muldiv_unit.sv
// HI/LO owner for the MIPS core: iterative 32-step multiply (shift-add) and
// restoring divide, plus MTHI/MTLO writes. busy is a pure state decode.
package muldiv_pkg;
    typedef logic [5:0] funct_t;
    localparam funct_t FUNCT_MULT  = 6'h18;
    localparam funct_t FUNCT_MULTU = 6'h19;
    localparam funct_t FUNCT_DIV   = 6'h1a;
    localparam funct_t FUNCT_DIVU  = 6'h1b;
endpackage

module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  funct_t      fncode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;
    logic        load, step;

    logic        is_div_q, sa_q, sb_q, bz_q;
    logic [31:0] mcand_q, opnd_q, a_q;
    logic [63:0] acc_q;

    function automatic logic [31:0] abs32(input logic signed [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

    logic signed [31:0] a_s, b_s;
    logic        start_ok, sel_div, sel_signed;
    logic [31:0] abs_a, abs_b;

    assign a_s        = a;
    assign b_s        = b;
    assign sel_div    = (fncode == FUNCT_DIV) || (fncode == FUNCT_DIVU);
    assign sel_signed = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
    assign start_ok   = start && (sel_div || (fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU));
    assign abs_a      = sel_signed ? abs32(a_s) : a;
    assign abs_b      = sel_signed ? abs32(b_s) : b;

    // Multiply: opnd_q is the multiplier, consumed LSB first.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[63:32]} + (opnd_q[0] ? {1'b0, mcand_q} : 33'd0);
    assign mul_next = {mul_sum, acc_q[31:1]};

    // Divide: opnd_q is the dividend, fed MSB first into the remainder.
    logic [31:0] rem_sh;
    logic [32:0] trial;
    logic [63:0] div_next;
    assign rem_sh   = {acc_q[62:32], opnd_q[31]};
    assign trial    = {1'b0, rem_sh} - {1'b0, mcand_q};
    assign div_next = trial[32] ? {rem_sh, acc_q[30:0], 1'b0}
                                : {trial[31:0], acc_q[30:0], 1'b1};

    logic [63:0] prod;
    logic [31:0] fix_hi, fix_lo;
    always_comb begin
        prod   = cond_neg64(acc_q, sa_q ^ sb_q);
        fix_hi = prod[63:32];
        fix_lo = prod[31:0];
        if (is_div_q) begin
            if (bz_q) begin
                fix_hi = a_q;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = cond_neg32(acc_q[63:32], sa_q);
                fix_lo = cond_neg32(acc_q[31:0], sa_q ^ sb_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    load    = 1'b1;
                    cnt_d   = 5'd0;
                    state_d = S_RUN;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_FIX;
            end
            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Working registers carry no reset; they are always reloaded on start.
    always_ff @(posedge clk) begin
        if (load) begin
            is_div_q <= sel_div;
            sa_q     <= sel_signed & a[31];
            sb_q     <= sel_signed & b[31];
            bz_q     <= (b == 32'd0);
            a_q      <= a;
            mcand_q  <= sel_div ? abs_b : abs_a;
            opnd_q   <= sel_div ? abs_a : abs_b;
            acc_q    <= 64'd0;
        end else if (step) begin
            acc_q    <= is_div_q ? div_next : mul_next;
            opnd_q   <= is_div_q ? {opnd_q[30:0], 1'b0} : {1'b0, opnd_q[31:1]};
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed MULT/DIV vectors, HI/LO writes,
// busy/done timing and mid-operation reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, start, mthi, mtlo;
    funct_t      fncode;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .fncode(fncode),
        .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, hi, e.hi);
                chk({e.name, "_lo"}, lo, e.lo);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout busy actual=1 expected=0");
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL wait_done_timeout done actual=0 expected=1");
        end
    endtask

    task automatic issue(input funct_t f, input logic [31:0] aa, input logic [31:0] bb,
                         input logic expect_result, input string nm,
                         input logic [31:0] eh, input logic [31:0] el);
        wait_idle();
        if (expect_result) sb.push_back('{name: nm, hi: eh, lo: el});
        start  = 1'b1;
        fncode = f;
        a      = aa;
        b      = bb;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    initial begin
        int n_busy, n_done, d0;
        reset_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        fncode = FUNCT_MULTU; a = '0; b = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
        n_busy = 0;
        n_done = 0;
        repeat (40) begin
            if (busy) n_busy++;
            if (done) n_done++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", n_busy, 32'd33);
        chk("done_pulses", n_done, 32'd1);

        issue(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, "mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        wait_done();
        issue(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        wait_done();
        issue(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf", 32'h0, 32'h8000_0000);
        wait_done();
        issue(FUNCT_DIVU, 32'd100, 32'd0, 1'b1, "divu_zero", 32'h64, 32'hFFFF_FFFF);
        wait_done();
        issue(FUNCT_DIVU, 32'd100, 32'd7, 1'b1, "divu_b2b", 32'd2, 32'd14);
        wait_done();
        @(posedge clk); #1;

        mthi  = 1'b1;
        wdata = 32'h1234_5678;
        #1;
        chk("hi_no_bypass", hi, 32'd2);
        @(posedge clk); #1;
        mthi = 1'b0;
        chk("hi_mthi", hi, 32'h1234_5678);
        chk("lo_kept", lo, 32'd14);

        issue(FUNCT_MULTU, 32'd3, 32'd5, 1'b1, "multu_3x5", 32'd0, 32'd15);
        repeat (5) @(posedge clk);
        #1;
        mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        start = 1'b1; fncode = FUNCT_DIVU; a = 32'd9; b = 32'd3;
        @(posedge clk); #1;
        mtlo = 1'b0; start = 1'b0;
        chk("lo_mtlo_run", lo, 32'd14);
        chk("hi_during_run", hi, 32'h1234_5678);
        wait_done();
        @(posedge clk); #1;

        mthi  = 1'b1;
        wdata = 32'hAAAA_5555;
        issue(FUNCT_MULTU, 32'd2, 32'd3, 1'b1, "multu_2x3", 32'd0, 32'd6);
        mthi = 1'b0;
        chk("hi_start_wins", hi, 32'd0);
        wait_done();
        @(posedge clk); #1;

        issue(FUNCT_MULTU, 32'd5, 32'd9, 1'b0, "multu_aborted", 32'd0, 32'd45);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        reset_n = 1'b1;
        d0 = done_seen;
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_seen - d0, 32'd0);

        issue(FUNCT_MULTU, 32'd6, 32'd7, 1'b1, "multu_6x7", 32'd0, 32'd42);
        wait_done();
        @(posedge clk); #1;
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
